systolic_tile_engine: RTL and testbench
=======================================

# systolic_tile_engine

Parametrised output-stationary systolic matrix-multiply engine. It computes one ROWS x COLS tile of C = A x B over a streamed inner dimension K of any length ≥ 1, or accumulates onto the previous tile (C += A x B). Input skewing, pipeline flush and row-by-row result drain are internal. It sits between the operand-fetch streams and the result writeback, replacing the square, free-running array that needed externally skewed inputs.

## Interface
- ROWS, 4, PE rows (≥1); number of A elements per beat, number of output rows
- COLS, 4, PE columns (≥1); number of B elements per beat, number of C elements per output beat
- DATA_WIDTH, 16, signed operand width
- ACCUM_WIDTH, 40, signed accumulator width; must be ≥ 2*DATA_WIDTH
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  engine accepts a beat (high in IDLE and LOAD)
- in_a_flat  in  ROWS*DATA_WIDTH  column k of A; A[i][k] at [(i+1)*DATA_WIDTH-1 -: DATA_WIDTH]
- in_b_flat  in  COLS*DATA_WIDTH  row k of B; B[k][j] at [(j+1)*DATA_WIDTH-1 -: DATA_WIDTH]
- in_last  in  1  beat is k = K-1 of the tile
- in_acc  in  1  sampled on the first beat of a tile: 1 = accumulate onto existing C, 0 = start from zero
- out_valid  out  1  result row valid
- out_ready  in  1  consumer accepts a result row
- out_row_flat  out  COLS*ACCUM_WIDTH  C[r][j] at [(j+1)*ACCUM_WIDTH-1 -: ACCUM_WIDTH]
- out_row_idx  out  max(1,$clog2(ROWS))  row index r of the current output beat
- out_last  out  1  high with out_valid when r = ROWS-1
- busy  out  1  state ≠ IDLE

## Operation
- Beat accepted when in_valid && in_ready. The first accepted beat after IDLE starts a tile.
- Skew: A lane i passes through i registers; B lane j passes through j registers. A then propagates right and B down one PE per cycle. A "first" flag travels with the A data of the first beat.
- Datapath advances every cycle, unconditionally. A cycle with no accepted beat injects zeros into all lanes, with the first flag clear.
- PE[i][j]: acc <= (first ? 0 : acc) + a*b. The product is a full 2*DATA_WIDTH signed value, sign-extended to ACCUM_WIDTH. Sums wrap modulo 2^ACCUM_WIDTH; there is no saturation.
- in_acc=1 on the first beat suppresses the first flag, so the tile adds onto the C already held.
- FSM:
  - IDLE: in_ready=1. Accepted beat with in_last=0 -> LOAD. With in_last=1 -> FLUSH, or DRAIN if ROWS+COLS-2 = 0.
  - LOAD: in_ready=1. in_valid low means bubbles, which are allowed. Accepted beat with in_last=1 -> FLUSH (or DRAIN as above).
  - FLUSH: in_ready=0. Flush counter runs ROWS+COLS-2 cycles, then -> DRAIN.
  - DRAIN: in_ready=0, out_valid=1, out_row_flat = acc[r][*]. On out_valid && out_ready: if r = ROWS-1, then r <= 0 and -> IDLE; else r <= r+1.
- Accumulators hold their values during DRAIN and IDLE, because only zeros arrive.
- out_row_flat always shows acc row r, including when out_valid is low.

## Timing
- Reset values:
  - state IDLE, in_ready=1, out_valid=0, out_last=0, busy=0, r=0
  - all skew, PE pipeline and accumulator registers 0, so out_row_flat = 0
- Reset mid-tile, in any state: the tile is abandoned. Next cycle matches the reset values, and the partially drained C is lost.
- Last beat accepted in cycle T:
  - FLUSH covers cycles T+1..T+ROWS+COLS-2
  - out_valid rises in cycle T+ROWS+COLS-1 (for 4x4, T+7; for 1x1, T+1)
- Minimum drain is ROWS cycles, with out_ready held high. The next tile's first beat can be accepted in the cycle after the out_last handshake.
- Throughput: one beat per cycle in LOAD. No combinational path from in_valid to in_ready, or from out_ready to out_valid.
- out_ready is ignored when out_valid=0. in_last and in_acc are ignored unless a beat is accepted.

## Test plan
- Identity: 4x4, K=4, A=I, B[k][j]=10k+j, in_acc=0, back-to-back beats -> out_valid at T+7; rows read 0,1,2,3 / 10,11,12,13 / 20..23 / 30..33; out_last on row 3.
- Bubbles and single beat: K=1 tile with A=all 3, B=all -2 -> every C = -6. Repeat K=4 with in_valid low every other cycle -> results identical to back-to-back.
- Accumulate: tile 1 random A,B with K=5 and in_acc=0, then tile 2 with K=3 and in_acc=1 -> C equals the reference sum of both products. Tile 3 with in_acc=0 -> prior C discarded.
- Backpressure: random out_ready at 30% duty -> each row presented stable until accepted, in order, and in_ready stays 0 until the out_last handshake.
- Extremes/wrap: A=B=-32768 everywhere, K=8 -> each C = 8*2^30 = 2^33. With ACCUM_WIDTH=32 the same stimulus gives 0, confirming modulo wrap.
- Reset mid-LOAD (after 2 beats) and mid-DRAIN (after row 1) -> next cycle: in_ready=1, out_valid=0, out_row_flat=0. A following identity tile is correct.
- Non-square: ROWS=2, COLS=5, K=3 -> out_valid at T+6, exactly 2 output beats, correct values.

Source files
------------

// File: rtl/systolic_tile_engine.sv
// Output-stationary ROWS x COLS systolic matrix-multiply tile with internal input
// skew, flush sequencing and row-by-row result drain.
module systolic_tile_engine #(
  parameter int ROWS        = 4,
  parameter int COLS        = 4,
  parameter int DATA_WIDTH  = 16,
  parameter int ACCUM_WIDTH = 40
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [ROWS*DATA_WIDTH-1:0]             in_a_flat,
  input  logic [COLS*DATA_WIDTH-1:0]             in_b_flat,
  input  logic                                   in_last,
  input  logic                                   in_acc,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [COLS*ACCUM_WIDTH-1:0]            out_row_flat,
  output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] out_row_idx,
  output logic                                   out_last,
  output logic                                   busy
);

  localparam int PW        = 2 * DATA_WIDTH;
  localparam int IDX_W     = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int FLUSH_CYC = ROWS + COLS - 2;
  localparam int CNT_W     = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLUSH_CYC - 1);
  localparam logic [IDX_W-1:0] ROW_LAST = IDX_W'(ROWS - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DRAIN} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] row_q, row_d;
  logic             accept;

  logic signed [DATA_WIDTH-1:0]  a_inj   [ROWS];
  logic signed [DATA_WIDTH-1:0]  b_inj   [COLS];
  logic                          f_inj;
  logic signed [DATA_WIDTH-1:0]  a_sk_q  [ROWS][ROWS];
  logic                          f_sk_q  [ROWS][ROWS];
  logic signed [DATA_WIDTH-1:0]  b_sk_q  [COLS][COLS];
  logic signed [DATA_WIDTH-1:0]  a_pe    [ROWS][COLS];
  logic signed [DATA_WIDTH-1:0]  b_pe    [ROWS][COLS];
  logic                          f_pe    [ROWS][COLS];
  logic signed [DATA_WIDTH-1:0]  a_q     [ROWS][COLS];
  logic signed [DATA_WIDTH-1:0]  b_q     [ROWS][COLS];
  logic                          f_q     [ROWS][COLS];
  logic signed [PW-1:0]          prod    [ROWS][COLS];
  logic signed [ACCUM_WIDTH-1:0] acc_q   [ROWS][COLS];

  assign accept = in_valid && in_ready;

  // Unaccepted cycles inject zeros so the accumulators hold their value.
  always_comb begin
    for (int unsigned i = 0; i < ROWS; i++)
      a_inj[i] = accept ? in_a_flat[i*DATA_WIDTH +: DATA_WIDTH] : '0;
    for (int unsigned j = 0; j < COLS; j++)
      b_inj[j] = accept ? in_b_flat[j*DATA_WIDTH +: DATA_WIDTH] : '0;
    f_inj = accept && (state_q == S_IDLE) && !in_acc;
  end

  // Lane i of A (and its first flag) leaves the skew chain after i stages, lane j of B after j.
  always_comb begin
    for (int unsigned i = 0; i < ROWS; i++) begin
      for (int unsigned j = 0; j < COLS; j++) begin
        if (j == 0) begin
          if (i == 0) begin
            a_pe[i][j] = a_inj[i];
            f_pe[i][j] = f_inj;
          end else begin
            a_pe[i][j] = a_sk_q[i][(i == 0) ? 0 : i-1];
            f_pe[i][j] = f_sk_q[i][(i == 0) ? 0 : i-1];
          end
        end else begin
          a_pe[i][j] = a_q[i][(j == 0) ? 0 : j-1];
          f_pe[i][j] = f_q[i][(j == 0) ? 0 : j-1];
        end
        if (i == 0) begin
          if (j == 0) b_pe[i][j] = b_inj[j];
          else        b_pe[i][j] = b_sk_q[j][(j == 0) ? 0 : j-1];
        end else begin
          b_pe[i][j] = b_q[(i == 0) ? 0 : i-1][j];
        end
        prod[i][j] = PW'(a_pe[i][j]) * PW'(b_pe[i][j]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_sk_q <= '{default: '0};
      f_sk_q <= '{default: '0};
      b_sk_q <= '{default: '0};
      a_q    <= '{default: '0};
      b_q    <= '{default: '0};
      f_q    <= '{default: '0};
      acc_q  <= '{default: '0};
    end else begin
      for (int unsigned i = 0; i < ROWS; i++) begin
        a_sk_q[i][0] <= a_inj[i];
        f_sk_q[i][0] <= f_inj;
        for (int unsigned s = 1; s < ROWS; s++) begin
          a_sk_q[i][s] <= a_sk_q[i][s-1];
          f_sk_q[i][s] <= f_sk_q[i][s-1];
        end
      end
      for (int unsigned j = 0; j < COLS; j++) begin
        b_sk_q[j][0] <= b_inj[j];
        for (int unsigned s = 1; s < COLS; s++)
          b_sk_q[j][s] <= b_sk_q[j][s-1];
      end
      for (int unsigned i = 0; i < ROWS; i++) begin
        for (int unsigned j = 0; j < COLS; j++) begin
          a_q[i][j]   <= a_pe[i][j];
          b_q[i][j]   <= b_pe[i][j];
          f_q[i][j]   <= f_pe[i][j];
          acc_q[i][j] <= (f_pe[i][j] ? '0 : acc_q[i][j]) + ACCUM_WIDTH'(prod[i][j]);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    row_d   = row_q;
    case (state_q)
      S_IDLE, S_LOAD: begin
        if (accept) begin
          if (in_last) state_d = (FLUSH_CYC == 0) ? S_DRAIN : S_FLUSH;
          else         state_d = S_LOAD;
        end
      end
      S_FLUSH: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (out_ready) begin
          if (row_q == ROW_LAST) begin
            row_d   = '0;
            state_d = S_IDLE;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE) || (state_q == S_LOAD);
    out_valid = (state_q == S_DRAIN);
    busy      = (state_q != S_IDLE);
    out_last  = (state_q == S_DRAIN) && (row_q == ROW_LAST);
  end

  always_comb begin
    out_row_flat = '0;
    for (int unsigned i = 0; i < ROWS; i++)
      if (row_q == IDX_W'(i))
        for (int unsigned j = 0; j < COLS; j++)
          out_row_flat[j*ACCUM_WIDTH +: ACCUM_WIDTH] = acc_q[i][j];
  end

  assign out_row_idx = row_q;

endmodule

// File: tb/tb_systolic_tile_engine.sv
// Directed bench for systolic_tile_engine: a 4x4/40-bit instance and a 2x5/32-bit instance.
module tb_systolic_tile_engine;
  localparam int DW  = 16;
  localparam int AW  = 40;
  localparam int AW2 = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic         iv1, ir1, il1, ia1, ov1, ord1, ol1, bz1;
  logic [63:0]  a1;
  logic [63:0]  b1;
  logic [159:0] row1;
  logic [1:0]   idx1;
  logic         iv2, ir2, il2, ia2, ov2, ord2, ol2, bz2;
  logic [31:0]  a2;
  logic [79:0]  b2;
  logic [159:0] row2;
  logic [0:0]   idx2;

  systolic_tile_engine #(.ROWS(4), .COLS(4), .DATA_WIDTH(DW), .ACCUM_WIDTH(AW)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(iv1), .in_ready(ir1), .in_a_flat(a1), .in_b_flat(b1),
    .in_last(il1), .in_acc(ia1), .out_valid(ov1), .out_ready(ord1), .out_row_flat(row1),
    .out_row_idx(idx1), .out_last(ol1), .busy(bz1));

  systolic_tile_engine #(.ROWS(2), .COLS(5), .DATA_WIDTH(DW), .ACCUM_WIDTH(AW2)) u_dut2 (
    .clk(clk), .reset(reset), .in_valid(iv2), .in_ready(ir2), .in_a_flat(a2), .in_b_flat(b2),
    .in_last(il2), .in_acc(ia2), .out_valid(ov2), .out_ready(ord2), .out_row_flat(row2),
    .out_row_idx(idx2), .out_last(ol2), .busy(bz2));

  int     total = 0;
  int     bad   = 0;
  int     nr[2] = '{4, 2};
  int     nc[2] = '{4, 5};
  int     ma[4][8];
  int     mb[8][5];
  longint ec[2][4][5];
  int     tlast;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(got), $signed(exp));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic rdy(input int d);    return d ? ir2 : ir1; endfunction
  function automatic logic ovld(input int d);   return d ? ov2 : ov1; endfunction
  function automatic logic olst(input int d);   return d ? ol2 : ol1; endfunction
  function automatic logic bsy(input int d);    return d ? bz2 : bz1; endfunction
  function automatic logic [1:0] oidx(input int d); return d ? {1'b0, idx2} : idx1; endfunction
  function automatic logic [159:0] orow(input int d); return d ? row2 : row1; endfunction

  function automatic longint gotc(input int d, input int j);
    logic signed [39:0] v40;
    logic signed [31:0] v32;
    v40 = row1[j*40 +: 40];
    v32 = row2[j*32 +: 32];
    return d ? longint'(v32) : longint'(v40);
  endfunction

  function automatic longint wrapv(input longint x, input int aw);
    return (x <<< (64 - aw)) >>> (64 - aw);
  endfunction

  function automatic int r16();
    logic signed [15:0] v;
    v = 16'($urandom);
    return int'(v);
  endfunction

  task automatic drive(input int d, input bit v, input bit last, input bit acc, input int k);
    logic [63:0] av;
    logic [79:0] bv;
    av = '0;
    bv = '0;
    for (int i = 0; i < nr[d]; i++) av[i*16 +: 16] = 16'(ma[i][k]);
    for (int j = 0; j < nc[d]; j++) bv[j*16 +: 16] = 16'(mb[k][j]);
    if (d == 0) begin iv1 = v; il1 = last; ia1 = acc; a1 = av; b1 = bv[63:0]; end
    else        begin iv2 = v; il2 = last; ia2 = acc; a2 = av[31:0]; b2 = bv; end
  endtask

  task automatic rnd(input int d, input int kk);
    for (int k = 0; k < kk; k++) begin
      for (int i = 0; i < nr[d]; i++) ma[i][k] = r16();
      for (int j = 0; j < nc[d]; j++) mb[k][j] = r16();
    end
  endtask

  task automatic fill(input int va, input int vb);
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 4; i++) ma[i][k] = va;
      for (int j = 0; j < 5; j++) mb[k][j] = vb;
    end
  endtask

  task automatic fill_identity();
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 4; i++) ma[i][k] = (i == k) ? 1 : 0;
      for (int j = 0; j < 5; j++) mb[k][j] = 10*k + j;
    end
  endtask

  // Reference product: C = (acc ? C : 0) + A x B, wrapped to the instance accumulator width.
  task automatic send(input int d, input int kk, input bit acc, input bit bubble);
    int g;
    for (int i = 0; i < nr[d]; i++)
      for (int j = 0; j < nc[d]; j++) begin
        longint s = acc ? ec[d][i][j] : 0;
        for (int k = 0; k < kk; k++) s += longint'(ma[i][k]) * longint'(mb[k][j]);
        ec[d][i][j] = wrapv(s, d ? AW2 : AW);
      end
    for (int k = 0; k < kk; k++) begin
      if (bubble && k > 0) begin
        drive(d, 1'b0, 1'b1, !acc, k);
        step();
      end
      drive(d, 1'b1, k == kk-1, acc, k);
      g = 0;
      while (!rdy(d) && g < 50) begin step(); g++; end
      if (g >= 50) chk("ready_timeout", 0, 1);
      if (k == kk-1) tlast = cyc;
      step();
    end
    drive(d, 1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic collect(input int d, input int pct, input int nrows);
    int g = 0;
    int r = 0;
    bit hold = 0;
    logic [159:0] prev;
    logic rd;
    while (!ovld(d) && g < 40) begin step(); g++; end
    chk($sformatf("d%0d_latency", d), cyc - tlast, nr[d] + nc[d] - 1);
    prev = orow(d);
    while (r < nrows && g < 400) begin
      rd = ($urandom_range(0, 99) < pct);
      if (d == 0) ord1 = rd; else ord2 = rd;
      chk($sformatf("d%0d_ovalid_r%0d", d, r), ovld(d), 1);
      chk($sformatf("d%0d_inready_drain", d), rdy(d), 0);
      if (hold) chk($sformatf("d%0d_stable_r%0d", d, r), {63'b0, orow(d) === prev}, 1);
      if (rd) begin
        chk($sformatf("d%0d_idx", d), oidx(d), r);
        for (int j = 0; j < nc[d]; j++)
          chk($sformatf("d%0d_c%0d%0d", d, r, j), gotc(d, j), ec[d][r][j]);
        chk($sformatf("d%0d_olast_r%0d", d, r), olst(d), r == nr[d]-1);
        r++;
        hold = 0;
      end else begin
        hold = 1;
      end
      prev = orow(d);
      step();
      g++;
    end
    ord1 = 1'b0;
    ord2 = 1'b0;
    if (r < nrows) chk($sformatf("d%0d_drain_timeout", d), r, nrows);
    if (nrows == nr[d]) begin
      chk($sformatf("d%0d_idle_ready", d), rdy(d), 1);
      chk($sformatf("d%0d_idle_ovalid", d), ovld(d), 0);
    end
  endtask

  task automatic chk_reset(input int d);
    chk($sformatf("d%0d_rst_ready", d), rdy(d), 1);
    chk($sformatf("d%0d_rst_ovalid", d), ovld(d), 0);
    chk($sformatf("d%0d_rst_olast", d), olst(d), 0);
    chk($sformatf("d%0d_rst_busy", d), bsy(d), 0);
    chk($sformatf("d%0d_rst_idx", d), oidx(d), 0);
    chk($sformatf("d%0d_rst_row", d), {63'b0, orow(d) === 160'b0}, 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    chk_reset(0);
    chk_reset(1);
    reset = 1'b0;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 5; j++) ec[d][i][j] = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    ord1 = 1'b0;
    ord2 = 1'b0;
    fill(0, 0);
    drive(0, 1'b0, 1'b0, 1'b0, 0);
    drive(1, 1'b0, 1'b0, 1'b0, 0);
    step();
    do_reset();
    step();

    // Identity: rows read 10r+j, out_valid at T+7.
    fill_identity();
    send(0, 4, 1'b0, 1'b0);
    collect(0, 100, 4);

    // Single beat: every C = 3 * -2 = -6.
    fill(3, -2);
    send(0, 1, 1'b0, 1'b0);
    collect(0, 100, 4);

    // Same operands back-to-back and with bubbles.
    rnd(0, 4);
    send(0, 4, 1'b0, 1'b0);
    collect(0, 100, 4);
    send(0, 4, 1'b0, 1'b1);
    collect(0, 100, 4);

    // Accumulate across tiles under output backpressure, then restart from zero.
    rnd(0, 5);
    send(0, 5, 1'b0, 1'b0);
    collect(0, 30, 4);
    rnd(0, 3);
    send(0, 3, 1'b1, 1'b1);
    collect(0, 30, 4);
    rnd(0, 2);
    send(0, 2, 1'b0, 1'b0);
    collect(0, 100, 4);

    // Extremes: 8 * (-32768)^2 = 2^33 fits in 40 bits.
    fill(-32768, -32768);
    send(0, 8, 1'b0, 1'b0);
    collect(0, 100, 4);

    // Reset mid-LOAD after two beats.
    rnd(0, 2);
    drive(0, 1'b1, 1'b0, 1'b0, 0);
    step();
    drive(0, 1'b1, 1'b0, 1'b0, 1);
    step();
    drive(0, 1'b0, 1'b0, 1'b0, 0);
    do_reset();

    // Reset mid-DRAIN after rows 0 and 1, then a clean identity tile.
    fill_identity();
    send(0, 4, 1'b0, 1'b0);
    collect(0, 100, 2);
    do_reset();
    fill_identity();
    send(0, 4, 1'b0, 1'b0);
    collect(0, 100, 4);

    // Non-square 2x5: out_valid at T+6, exactly two output rows.
    rnd(1, 3);
    send(1, 3, 1'b0, 1'b0);
    collect(1, 100, 2);
    step();
    chk("d1_no_third_row", ov2, 0);

    // 32-bit accumulator: 2^33 wraps to 0.
    fill(-32768, -32768);
    send(1, 8, 1'b0, 1'b0);
    collect(1, 100, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
